cpu_run_io_wrapper: RTL and testbench
=====================================

// Module: cpu_run_io_wrapper
// PURPOSE
//  Parametrised run-control and output-capture wrapper between board I/O and the CPU core.
//  Gates the core enable through a run/step/breakpoint FSM.
//  Buffers retired OUT_RESULT values in a show-ahead FIFO with a valid/ready readout.
//  Drives N_OUT board output channels, each with a selectable source.
// PARAMETERS
//  DATA_W  8  width of core result / FIFO entry
//  PC_W    8  width of core program counter
//  FLAG_W  4  width of core flag vector
//  DEPTH   8  FIFO entries; power of 2, >=2
//  N_OUT   3  number of board output channels
// PORTS
//  CLK           in   1          single clock, rising edge
//  ASYN_CLR      in   1          asynchronous, active-low reset
//  RUN_REQ       in   1          level: free-run request (board switch)
//  STEP_REQ      in   1          rising edge requests one core cycle
//  BRK_EN        in   1          breakpoint enable
//  BRK_PC        in   PC_W       breakpoint address
//  CORE_EN       out  1          enable to core (CPU_EN)
//  CORE_PC       in   PC_W       core PC_OUT
//  CORE_RESULT   in   DATA_W     core OUT_RESULT
//  CORE_OUT_VLD  in   1          core retires an output instruction this cycle
//  CORE_FLAGS    in   FLAG_W     core FLAG_OUT; bit 0 = zero flag
//  CORE_DOUT     in   1          core DOUT
//  RD_VLD        out  1          FIFO head valid
//  RD_DATA       out  DATA_W     FIFO head (show-ahead)
//  RD_RDY        in   1          consumer accepts head
//  OVF           out  1          sticky FIFO overflow
//  STATE         out  2          FSM state (0 IDLE, 1 RUN, 2 STEP, 3 HALT)
//  CH_SEL        in   2*N_OUT    per-channel source select
//  OUT_CH        out  N_OUT      board output channels
// BEHAVIOUR
//  Reset (ASYN_CLR=0, immediate):
//   - STATE=IDLE, FIFO empty, RD_VLD=0, OVF=0, OUT_CH=0.
//   - STEP_REQ edge register =1, so a held STEP_REQ is not an edge.
//  Reset mid-run: the FIFO contents are discarded.
//  step_edge = STEP_REQ & ~STEP_REQ_q.
//  brk_hit = BRK_EN & (CORE_PC==BRK_PC).
//  CORE_EN (combinational) = (STATE==RUN & ~brk_hit) | (STATE==STEP).
//  FSM transitions, evaluated in priority order:
//   - IDLE: RUN_REQ -> RUN; else step_edge -> STEP; else stay.
//     RUN wins over a simultaneous step.
//   - RUN: ~RUN_REQ -> IDLE; else brk_hit -> HALT.
//     The instruction at BRK_PC is not executed.
//   - STEP: exactly one CORE_EN cycle, then -> IDLE.
//     Steps in STEP are ignored.
//   - HALT: ~RUN_REQ -> IDLE; else step_edge -> STEP, executing the breakpoint instruction.
//     Re-entering RUN needs RUN_REQ low then high.
//  FIFO:
//   - wr = CORE_OUT_VLD & CORE_EN; rd = RD_VLD & RD_RDY.
//   - Count width is clog2(DEPTH)+1; pointers wrap modulo DEPTH.
//   - RD_VLD = count!=0; RD_DATA = mem[rd_ptr]. A write is visible 1 cycle later.
//   - Full with wr and no rd: entry dropped, OVF set until reset.
//   - Full with wr and rd: both complete, count unchanged, no OVF.
//   - Empty with wr: no read occurs (RD_VLD=0).
//  OUT_CH[i]:
//   - Registered, 1-cycle latency.
//   - Source by CH_SEL[2i+1:2i]: 0 CORE_DOUT, 1 CORE_EN, 2 OVF, 3 CORE_FLAGS[0].
// TESTING
//  1. Reset, RUN_REQ=1 -> STATE=1 next cycle, CORE_EN=1.
//     RUN_REQ=0 -> STATE=0, CORE_EN=0.
//  2. BRK_EN=1, BRK_PC=8'h05, run with PC counting 0..5 -> CORE_EN=0 in the cycle PC==5,
//     STATE=3. One STEP_REQ pulse -> exactly 1 CORE_EN cycle, STATE=0.
//  3. IDLE, STEP_REQ held high for 5 cycles -> one CORE_EN pulse only.
//     STEP_REQ high at reset release -> no step.
//  4. Write 8 results 0x10..0x17 with RD_RDY=0 -> RD_VLD=1, RD_DATA=0x10.
//     9th write (0x18) dropped, OVF=1. Drain reads 0x10..0x17 in order, then RD_VLD=0.
//  5. Full FIFO, write 0xAA with RD_RDY=1 in the same cycle -> head advances, count stays 8,
//     OVF=0, 0xAA read last.
//  6. CH_SEL=6'b10_01_00, N_OUT=3 -> OUT_CH = {OVF, CORE_EN, CORE_DOUT} delayed 1 cycle.
//     Assert ASYN_CLR=0 mid-run -> all outputs 0 without waiting for a clock.

Source files
------------

// File: rtl/cpu_run_io_wrapper.sv
// Run-control and output-capture wrapper between board I/O and the CPU core.
// Gates the core enable, buffers retired results in a show-ahead FIFO and drives board outputs.
module cpu_run_io_wrapper #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 8,
  parameter int N_OUT  = 3
) (
  input  logic                 CLK,
  input  logic                 ASYN_CLR,
  input  logic                 RUN_REQ,
  input  logic                 STEP_REQ,
  input  logic                 BRK_EN,
  input  logic [PC_W-1:0]      BRK_PC,
  output logic                 CORE_EN,
  input  logic [PC_W-1:0]      CORE_PC,
  input  logic [DATA_W-1:0]    CORE_RESULT,
  input  logic                 CORE_OUT_VLD,
  input  logic [FLAG_W-1:0]    CORE_FLAGS,
  input  logic                 CORE_DOUT,
  output logic                 RD_VLD,
  output logic [DATA_W-1:0]    RD_DATA,
  input  logic                 RD_RDY,
  output logic                 OVF,
  output logic [1:0]           STATE,
  input  logic [2*N_OUT-1:0]   CH_SEL,
  output logic [N_OUT-1:0]     OUT_CH
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   step_q;
  logic   step_edge, brk_hit;
  logic   unused_flags;

  assign unused_flags = ^CORE_FLAGS;
  assign step_edge    = STEP_REQ & ~step_q;
  assign brk_hit      = BRK_EN & (CORE_PC == BRK_PC);
  assign CORE_EN      = ((state_q == S_RUN) & ~brk_hit) | (state_q == S_STEP);
  assign STATE        = state_q;

  // step_q resets high so a STEP_REQ held through reset release is not an edge
  always_ff @(posedge CLK or negedge ASYN_CLR) begin
    if (!ASYN_CLR) begin
      state_q <= S_IDLE;
      step_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= STEP_REQ;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (RUN_REQ)        state_d = S_RUN;
        else if (step_edge) state_d = S_STEP;
      end
      S_RUN: begin
        if (!RUN_REQ)       state_d = S_IDLE;
        else if (brk_hit)   state_d = S_HALT;
      end
      S_STEP:               state_d = S_IDLE;
      S_HALT: begin
        if (!RUN_REQ)       state_d = S_IDLE;
        else if (step_edge) state_d = S_STEP;
      end
      default:              state_d = S_IDLE;
    endcase
  end

  // Show-ahead FIFO. When full, a write only lands if a read frees a slot in the same cycle.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              wr, rd, full, do_wr;

  assign wr      = CORE_OUT_VLD & CORE_EN;
  assign rd      = RD_VLD & RD_RDY;
  assign full    = (count == FULL_CNT);
  assign do_wr   = wr & (~full | rd);
  assign RD_VLD  = (count != '0);
  assign RD_DATA = mem[rd_ptr];

  always_ff @(posedge CLK or negedge ASYN_CLR) begin
    if (!ASYN_CLR) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      OVF    <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= CORE_RESULT;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_wr && !rd)      count <= count + CNT_ONE;
      else if (!do_wr && rd) count <= count - CNT_ONE;
      if (wr && full && !rd) OVF <= 1'b1;
    end
  end

  logic [N_OUT-1:0] out_d;

  always_comb begin
    out_d = '0;
    for (int i = 0; i < N_OUT; i++) begin
      unique case (CH_SEL[2*i +: 2])
        2'd0: out_d[i] = CORE_DOUT;
        2'd1: out_d[i] = CORE_EN;
        2'd2: out_d[i] = OVF;
        2'd3: out_d[i] = CORE_FLAGS[0];
        default: out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ASYN_CLR) begin
    if (!ASYN_CLR) OUT_CH <= '0;
    else           OUT_CH <= out_d;
  end

endmodule

// File: tb/tb_cpu_run_io_wrapper.sv
// Directed bench for cpu_run_io_wrapper: run/step/breakpoint control, FIFO capture, output muxing.
module tb_cpu_run_io_wrapper;

  logic       CLK = 1'b0;
  logic       ASYN_CLR;
  logic       RUN_REQ, STEP_REQ, BRK_EN;
  logic [7:0] BRK_PC, CORE_PC, CORE_RESULT;
  logic       CORE_EN, CORE_OUT_VLD, CORE_DOUT;
  logic [3:0] CORE_FLAGS;
  logic       RD_VLD, RD_RDY, OVF;
  logic [7:0] RD_DATA;
  logic [1:0] STATE;
  logic [5:0] CH_SEL;
  logic [2:0] OUT_CH;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt;

  cpu_run_io_wrapper dut (
    .CLK(CLK), .ASYN_CLR(ASYN_CLR), .RUN_REQ(RUN_REQ), .STEP_REQ(STEP_REQ),
    .BRK_EN(BRK_EN), .BRK_PC(BRK_PC), .CORE_EN(CORE_EN), .CORE_PC(CORE_PC),
    .CORE_RESULT(CORE_RESULT), .CORE_OUT_VLD(CORE_OUT_VLD), .CORE_FLAGS(CORE_FLAGS),
    .CORE_DOUT(CORE_DOUT), .RD_VLD(RD_VLD), .RD_DATA(RD_DATA), .RD_RDY(RD_RDY),
    .OVF(OVF), .STATE(STATE), .CH_SEL(CH_SEL), .OUT_CH(OUT_CH)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // inputs change 2 time units after a rising edge; checks happen 2 units later
  task automatic next();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic fill_fifo(input logic [7:0] base);
    RUN_REQ = 1'b1;
    next();
    CORE_OUT_VLD = 1'b1;
    for (int i = 0; i < 8; i++) begin
      CORE_RESULT = base + 8'(i);
      next();
    end
  endtask

  initial begin
    ASYN_CLR = 1'b0; RUN_REQ = 1'b0; STEP_REQ = 1'b1; BRK_EN = 1'b0;
    BRK_PC = 8'h00; CORE_PC = 8'h00; CORE_RESULT = 8'h00; CORE_OUT_VLD = 1'b0;
    CORE_FLAGS = 4'h0; CORE_DOUT = 1'b0; RD_RDY = 1'b0; CH_SEL = 6'b0;

    repeat (2) next();
    check("rst_state", STATE, 0);
    check("rst_core_en", CORE_EN, 0);
    check("rst_rd_vld", RD_VLD, 0);
    check("rst_ovf", OVF, 0);
    check("rst_out_ch", OUT_CH, 0);

    // STEP_REQ held high across reset release must not step
    ASYN_CLR = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      next();
      settle();
      en_cnt += int'(CORE_EN);
    end
    check("held_step_at_release", en_cnt, 0);
    check("held_step_state", STATE, 0);
    STEP_REQ = 1'b0;

    // free run on / off
    RUN_REQ = 1'b1;
    settle();
    check("run_pre_edge", STATE, 0);
    next(); settle();
    check("run_state", STATE, 1);
    check("run_core_en", CORE_EN, 1);
    RUN_REQ = 1'b0;
    next(); settle();
    check("stop_state", STATE, 0);
    check("stop_core_en", CORE_EN, 0);

    // breakpoint at PC 5
    BRK_EN = 1'b1; BRK_PC = 8'h05; CORE_PC = 8'h00; RUN_REQ = 1'b1;
    next();
    for (int pc = 0; pc < 6; pc++) begin
      CORE_PC = 8'(pc);
      settle();
      check($sformatf("brk_en_pc%0d", pc), CORE_EN, (pc != 5));
      check($sformatf("brk_state_pc%0d", pc), STATE, 1);
      next();
    end
    settle();
    check("halt_state", STATE, 3);
    check("halt_core_en", CORE_EN, 0);
    next(); settle();
    check("halt_holds", STATE, 3);
    STEP_REQ = 1'b1;
    next();
    STEP_REQ = 1'b0;
    settle();
    check("brk_step_state", STATE, 2);
    check("brk_step_en", CORE_EN, 1);
    next();
    RUN_REQ = 1'b0;
    settle();
    check("brk_step_done", STATE, 0);
    check("brk_step_done_en", CORE_EN, 0);
    BRK_EN = 1'b0;

    // held STEP_REQ gives one core cycle only
    next();
    STEP_REQ = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      next();
      if (i == 4) STEP_REQ = 1'b0;
      settle();
      en_cnt += int'(CORE_EN);
    end
    check("held_step_pulses", en_cnt, 1);
    check("held_step_idle", STATE, 0);

    // fill, overflow, drain
    fill_fifo(8'h10);
    settle();
    check("full_rd_vld", RD_VLD, 1);
    check("full_head", RD_DATA, 8'h10);
    check("full_no_ovf", OVF, 0);
    CORE_RESULT = 8'h18;
    next();
    CORE_OUT_VLD = 1'b0; RUN_REQ = 1'b0;
    settle();
    check("ovf_set", OVF, 1);
    check("ovf_head", RD_DATA, 8'h10);
    RD_RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check($sformatf("drain_vld%0d", i), RD_VLD, 1);
      check($sformatf("drain_data%0d", i), RD_DATA, 8'h10 + 8'(i));
      @(posedge CLK); #2;
    end
    settle();
    check("drain_empty", RD_VLD, 0);
    check("ovf_sticky", OVF, 1);
    RD_RDY = 1'b0;

    // output channels: ch2=OVF, ch1=CORE_EN, ch0=CORE_DOUT, one cycle late
    next();
    CH_SEL = 6'b10_01_00; RUN_REQ = 1'b1; CORE_DOUT = 1'b1;
    next();
    CORE_DOUT = 1'b0;
    settle();
    check("out_a", OUT_CH, 3'b101);
    next();
    CORE_DOUT = 1'b1; RUN_REQ = 1'b0;
    settle();
    check("out_b", OUT_CH, 3'b110);
    next();
    CORE_DOUT = 1'b0;
    settle();
    check("out_c", OUT_CH, 3'b111);
    CH_SEL = 6'b11_11_11; CORE_FLAGS = 4'b0001;
    settle();
    check("out_latency", OUT_CH, 3'b111);
    next();
    CORE_FLAGS = 4'b1110;
    settle();
    check("out_flag_set", OUT_CH, 3'b111);
    next(); settle();
    check("out_flag_clr", OUT_CH, 3'b000);

    // async reset mid-run discards FIFO contents
    CH_SEL = 6'b10_01_00; CORE_DOUT = 1'b1; RUN_REQ = 1'b1;
    next();
    CORE_OUT_VLD = 1'b1; CORE_RESULT = 8'h55;
    next();
    CORE_OUT_VLD = 1'b0;
    settle();
    check("pre_rst_out", OUT_CH, 3'b111);
    check("pre_rst_vld", RD_VLD, 1);
    check("pre_rst_data", RD_DATA, 8'h55);
    ASYN_CLR = 1'b0;
    #1;
    check("arst_state", STATE, 0);
    check("arst_core_en", CORE_EN, 0);
    check("arst_rd_vld", RD_VLD, 0);
    check("arst_rd_data", RD_DATA, 0);
    check("arst_ovf", OVF, 0);
    check("arst_out_ch", OUT_CH, 0);
    RUN_REQ = 1'b0; CORE_DOUT = 1'b0; CH_SEL = 6'b0;
    next();
    ASYN_CLR = 1'b1;
    next();

    // full FIFO with simultaneous write and read
    fill_fifo(8'h20);
    CORE_RESULT = 8'hAA; RD_RDY = 1'b1;
    next();
    CORE_OUT_VLD = 1'b0; RD_RDY = 1'b0; RUN_REQ = 1'b0;
    settle();
    check("wr_rd_full_head", RD_DATA, 8'h21);
    check("wr_rd_full_ovf", OVF, 0);
    RD_RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check($sformatf("wr_rd_vld%0d", i), RD_VLD, 1);
      check($sformatf("wr_rd_data%0d", i), RD_DATA, (i == 7) ? 8'hAA : 8'h21 + 8'(i));
      @(posedge CLK); #2;
    end
    settle();
    check("wr_rd_empty", RD_VLD, 0);
    RD_RDY = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
